chacha20_keystream_scheduler: RTL and testbench
===============================================

// Module: chacha20_keystream_scheduler
// PURPOSE
//  Sequences one chacha20_block instance to produce a stream of 512-bit keystream blocks.
//  - Latches key, nonce and initial counter on a config load.
//  - Builds the 16-word ChaCha20 state, launches the block and waits for it to finish.
//  - Presents each result on a valid/ready stream, then increments the counter and relaunches.
//  - Sits between the config/consumer logic and the chacha20_block datapath.
// PARAMETERS
//  ALLOW_COUNTER_WRAP  0  1: counter wraps 0xFFFFFFFF->0 and streaming continues; 0: stop and flag exhausted
// PORTS
//  clock               in   1    single clock, rising edge
//  clear_n             in   1    asynchronous active-low reset
//  cfg_load            in   1    load config; accepted only when cfg_ready=1
//  cfg_key             in   256  key words k0..k7, kN at [32N+31:32N]
//  cfg_nonce           in   96   nonce words n0..n2, nN at [32N+31:32N]
//  cfg_counter         in   32   initial block counter
//  cfg_ready           out  1    1 while in IDLE
//  stop                in   1    abandon stream, return to IDLE
//  ks_valid            out  1    keystream block available
//  ks_ready            in   1    consumer accepts block when ks_valid & ks_ready
//  ks_data             out  512  keystream block (chacha20_block round_output)
//  ks_counter          out  32   counter value used for ks_data
//  exhausted           out  1    sticky: counter 0xFFFFFFFF consumed with ALLOW_COUNTER_WRAP=0
//  block_round_input   out  512  to chacha20_block round_input
//  block_start         out  1    to chacha20_block start
//  block_finished      in   1    from chacha20_block finished (1 = idle/done)
//  block_round_output  in   512  from chacha20_block round_output
// BEHAVIOUR
//  Reset: state=IDLE; ks_valid=0, ks_data=0, ks_counter=0, exhausted=0; key/nonce/counter regs=0.
//   cfg_ready=1 and block_start=0 while in reset.
//  State words, word W at block_round_input[32W+31:32W]:
//   W0..3 = 61707865,3320646e,79622d32,6b206574; W4..11 = k0..k7; W12 = counter; W13..15 = n0..n2.
//  block_start = (state==LAUNCH) & block_finished & ~stop. Combinational; block_round_input registered.
//  FSM:
//   IDLE: on cfg_load, latch key/nonce/counter, clear exhausted -> LAUNCH. stop has no effect here.
//   LAUNCH: stop -> IDLE. Else wait for block_finished=1 (block may still be busy after reset).
//    When block_start is asserted -> WAIT_BUSY.
//   WAIT_BUSY: wait for block_finished=0 -> WAIT_DONE.
//   WAIT_DONE: on block_finished=1, capture block_round_output into ks_data, counter into ks_counter.
//    If no abort is pending: ks_valid<=1 -> HOLD. If abort pending: discard result, no ks_valid -> IDLE.
//   HOLD: ks_valid=1; ks_data and ks_counter held stable until handshake.
//    On ks_valid & ks_ready: ks_valid<=0 next edge. If counter==FFFFFFFF & !ALLOW_COUNTER_WRAP:
//    exhausted<=1 -> IDLE. Else counter<=counter+1 (mod 2^32) -> LAUNCH.
//    stop without ready -> ks_valid<=0 -> IDLE. stop & ready same cycle: block counts as consumed
//    (exhausted updates as above) -> IDLE.
//  stop in WAIT_BUSY/WAIT_DONE sets abort_pending; the in-flight block always runs to completion.
//   abort_pending clears on entering IDLE.
//  cfg_load outside IDLE is ignored; config regs never change mid-stream.
//  Latency: cfg_load edge -> block_start high next cycle if block idle.
//   block_finished rise -> ks_valid high next cycle.
//   ks handshake -> next block_start one cycle later. Exactly one block in flight at any time.
//  Reset mid-operation (clear_n low): immediate async return to reset state. After release,
//   LAUNCH waits for block_finished=1 before issuing block_start.
// TESTING
//  1 RFC8439 2.3.2: key 00..1f, nonce 000000090000004a00000000, ctr 1 -> ks_data W0=e4e7f110,
//    ks_counter=1.
//  2 Backpressure: hold ks_ready=0 for 20 cycles -> ks_valid and ks_data stable.
//    Raise ready -> next block ks_counter=2.
//  3 Wrap: cfg_counter=FFFFFFFF, WRAP=0 -> one block, then exhausted=1, cfg_ready=1,
//    no further block_start. With WRAP=1: next ks_counter=0.
//  4 stop in WAIT_BUSY -> block completes, ks_valid never asserts, IDLE.
//    New cfg_load launches cleanly.
//  5 clear_n pulse while block busy -> outputs 0; after release no block_start until
//    block_finished=1.
//  6 cfg_load pulsed during HOLD -> ignored; ks_counter sequence unchanged.

Source files
------------

// File: rtl/chacha20_keystream_scheduler.sv
// chacha20_keystream_scheduler
//   Drives one chacha20_block instance to produce a stream of 512-bit
//   keystream blocks. Key, nonce and start counter are latched on a config
//   load. The scheduler builds the 16-word ChaCha20 state, launches the block
//   and waits for it to finish. Each result is offered on a valid/ready
//   stream, after which the counter advances and the next block is launched.
//
// Ports
//   clock, clear_n           rising-edge clock, asynchronous active-low reset
//   cfg_load/key/nonce/ctr   config load, accepted only while cfg_ready=1
//   cfg_ready                high while idle
//   stop                     abandon the stream and return to idle
//   ks_valid/ready/data/ctr  keystream output stream and its block counter
//   exhausted                sticky: last counter value consumed, no wrap
//   block_*                  interface to the chacha20_block datapath
module chacha20_keystream_scheduler #(
  parameter int unsigned ALLOW_COUNTER_WRAP = 0
) (
  input  logic         clock,
  input  logic         clear_n,
  input  logic         cfg_load,
  input  logic [255:0] cfg_key,
  input  logic [95:0]  cfg_nonce,
  input  logic [31:0]  cfg_counter,
  output logic         cfg_ready,
  input  logic         stop,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [511:0] ks_data,
  output logic [31:0]  ks_counter,
  output logic         exhausted,
  output logic [511:0] block_round_input,
  output logic         block_start,
  input  logic         block_finished,
  input  logic [511:0] block_round_output
);

  // "expand 32-byte k", word 0 in the least significant position
  localparam logic [127:0] SIGMA = 128'h6b206574_79622d32_3320646e_61707865;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_HOLD
  } state_e;

  state_e         state_q, state_d;
  logic [255:0]   key_q, key_d;
  logic [95:0]    nonce_q, nonce_d;
  logic [31:0]    counter_q, counter_d;
  logic           abort_q, abort_d;
  logic           ks_valid_q, ks_valid_d;
  logic [511:0]   ks_data_q, ks_data_d;
  logic [31:0]    ks_counter_q, ks_counter_d;
  logic           exhausted_q, exhausted_d;
  logic [511:0]   round_input_q, round_input_d;
  logic           last_counter;

  assign last_counter = (counter_q == '1) && (ALLOW_COUNTER_WRAP == 0);

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    nonce_d      = nonce_q;
    counter_d    = counter_q;
    abort_d      = abort_q;
    ks_valid_d   = ks_valid_q;
    ks_data_d    = ks_data_q;
    ks_counter_d = ks_counter_q;
    exhausted_d  = exhausted_q;
    block_start  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_load) begin
          key_d       = cfg_key;
          nonce_d     = cfg_nonce;
          counter_d   = cfg_counter;
          exhausted_d = 1'b0;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // The block may still be finishing a previous job (e.g. after reset).
        if (stop) begin
          state_d = S_IDLE;
        end else if (block_finished) begin
          block_start = 1'b1;
          state_d     = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (stop) abort_d = 1'b1;
        if (!block_finished) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (stop) abort_d = 1'b1;
        if (block_finished) begin
          // A stop arriving with the finish still discards the block.
          if (abort_q || stop) begin
            state_d = S_IDLE;
          end else begin
            ks_data_d    = block_round_output;
            ks_counter_d = counter_q;
            ks_valid_d   = 1'b1;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (ks_ready) begin
          ks_valid_d = 1'b0;
          if (last_counter) begin
            exhausted_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            counter_d = counter_q + 32'd1;
            state_d   = stop ? S_IDLE : S_LAUNCH;
          end
        end else if (stop) begin
          ks_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) abort_d = 1'b0;

    round_input_d = {nonce_d, counter_d, key_d, SIGMA};
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= S_IDLE;
      key_q         <= '0;
      nonce_q       <= '0;
      counter_q     <= '0;
      abort_q       <= 1'b0;
      ks_valid_q    <= 1'b0;
      ks_data_q     <= '0;
      ks_counter_q  <= '0;
      exhausted_q   <= 1'b0;
      round_input_q <= '0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      nonce_q       <= nonce_d;
      counter_q     <= counter_d;
      abort_q       <= abort_d;
      ks_valid_q    <= ks_valid_d;
      ks_data_q     <= ks_data_d;
      ks_counter_q  <= ks_counter_d;
      exhausted_q   <= exhausted_d;
      round_input_q <= round_input_d;
    end
  end

  assign cfg_ready         = (state_q == S_IDLE);
  assign ks_valid          = ks_valid_q;
  assign ks_data           = ks_data_q;
  assign ks_counter        = ks_counter_q;
  assign exhausted         = exhausted_q;
  assign block_round_input = round_input_q;

endmodule

// File: tb/tb_chacha20_keystream_scheduler.sv
module tb_chacha20_keystream_scheduler;

  logic         clock = 1'b0;
  logic         clear_n = 1'b0;
  logic         cfg_load = 1'b0;
  logic [255:0] cfg_key = '0;
  logic [95:0]  cfg_nonce = '0;
  logic [31:0]  cfg_counter = '0;
  logic         stop = 1'b0;
  logic         ks_ready = 1'b0;

  // index 0: ALLOW_COUNTER_WRAP=0, index 1: ALLOW_COUNTER_WRAP=1
  logic         cfg_ready [2];
  logic         ks_valid [2];
  logic [511:0] ks_data [2];
  logic [31:0]  ks_counter [2];
  logic         exhausted [2];
  logic [511:0] bri [2];
  logic         bstart [2];
  logic         bfin [2];
  logic [511:0] bout [2];

  int unsigned  lat = 4;
  int           tests_run = 0;
  int           fails = 0;

  always #5 clock = ~clock;

  chacha20_keystream_scheduler #(.ALLOW_COUNTER_WRAP(0)) dut0 (
    .clock(clock), .clear_n(clear_n), .cfg_load(cfg_load), .cfg_key(cfg_key),
    .cfg_nonce(cfg_nonce), .cfg_counter(cfg_counter), .cfg_ready(cfg_ready[0]),
    .stop(stop), .ks_valid(ks_valid[0]), .ks_ready(ks_ready), .ks_data(ks_data[0]),
    .ks_counter(ks_counter[0]), .exhausted(exhausted[0]), .block_round_input(bri[0]),
    .block_start(bstart[0]), .block_finished(bfin[0]), .block_round_output(bout[0]));

  chacha20_keystream_scheduler #(.ALLOW_COUNTER_WRAP(1)) dut1 (
    .clock(clock), .clear_n(clear_n), .cfg_load(cfg_load), .cfg_key(cfg_key),
    .cfg_nonce(cfg_nonce), .cfg_counter(cfg_counter), .cfg_ready(cfg_ready[1]),
    .stop(stop), .ks_valid(ks_valid[1]), .ks_ready(ks_ready), .ks_data(ks_data[1]),
    .ks_counter(ks_counter[1]), .exhausted(exhausted[1]), .block_round_input(bri[1]),
    .block_start(bstart[1]), .block_finished(bfin[1]), .block_round_output(bout[1]));

  // ---------------- ChaCha20 reference (RFC 8439) ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [15:0][31:0] qr(input logic [15:0][31:0] s,
      input int unsigned a, input int unsigned b, input int unsigned c, input int unsigned d);
    s[a] = s[a] + s[b]; s[d] = rotl(s[d] ^ s[a], 16);
    s[c] = s[c] + s[d]; s[b] = rotl(s[b] ^ s[c], 12);
    s[a] = s[a] + s[b]; s[d] = rotl(s[d] ^ s[a], 8);
    s[c] = s[c] + s[d]; s[b] = rotl(s[b] ^ s[c], 7);
    return s;
  endfunction

  function automatic logic [511:0] chacha_core(input logic [511:0] in);
    logic [15:0][31:0] x;
    logic [15:0][31:0] i0;
    x = in;
    i0 = in;
    for (int r = 0; r < 10; r++) begin
      x = qr(x, 0, 4, 8, 12);  x = qr(x, 1, 5, 9, 13);
      x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
      x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12);
      x = qr(x, 2, 7, 8, 13);  x = qr(x, 3, 4, 9, 14);
    end
    for (int w = 0; w < 16; w++) x[w] = x[w] + i0[w];
    return x;
  endfunction

  function automatic logic [511:0] build_state(input logic [255:0] k,
      input logic [95:0] n, input logic [31:0] c);
    logic [15:0][31:0] s;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4 + i] = k[32 * i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13 + i] = n[32 * i +: 32];
    return s;
  endfunction

  function automatic logic [511:0] expect_ks(input logic [255:0] k,
      input logic [95:0] n, input logic [31:0] c);
    return chacha_core(build_state(k, n, c));
  endfunction

  // ---------------- behavioural chacha20_block models ----------------
  for (genvar g = 0; g < 2; g++) begin : g_blk
    int unsigned  cnt = 0;
    int unsigned  starts = 0;
    int unsigned  overlaps = 0;
    logic [511:0] res = '0;
    assign bfin[g] = (cnt == 0);
    assign bout[g] = res;
    always @(posedge clock) begin
      if (bstart[g]) begin
        starts <= starts + 1;
        if (cnt != 0) overlaps <= overlaps + 1;
        cnt <= lat;
        res <= chacha_core(bri[g]);
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    cfg_key = k; cfg_nonce = n; cfg_counter = c; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic consume();
    ks_ready = 1'b1;
    step();
    ks_ready = 1'b0;
  endtask

  task automatic abandon();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Waits for ks_valid on dut0; lat_out = samples between finished rising and valid.
  task automatic wait_valid(input int budget, output bit ok, output int lat_out);
    int rise;
    bit pf;
    ok = 1'b0; lat_out = -1; rise = -1; pf = bfin[0];
    for (int c = 0; c < budget; c++) begin
      if (ks_valid[0]) begin
        ok = 1'b1;
        if (rise >= 0) lat_out = c - rise;
        return;
      end
      if (bfin[0] && !pf) rise = c;
      pf = bfin[0];
      step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_n = 1'b0;
    repeat (3) step();
    tests_run++; if (cfg_ready[0] !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready[0]); end
    tests_run++; if (ks_valid[0] !== 1'b0) begin fails++; $display("FAIL reset_ks_valid got %b want 0", ks_valid[0]); end
    tests_run++; if (ks_data[0] !== 512'd0) begin fails++; $display("FAIL reset_ks_data got %h want 0", ks_data[0]); end
    tests_run++; if (ks_counter[0] !== 32'd0) begin fails++; $display("FAIL reset_ks_counter got %h want 0", ks_counter[0]); end
    tests_run++; if (exhausted[0] !== 1'b0) begin fails++; $display("FAIL reset_exhausted got %b want 0", exhausted[0]); end
    tests_run++; if (bstart[0] !== 1'b0) begin fails++; $display("FAIL reset_block_start got %b want 0", bstart[0]); end
    clear_n = 1'b1;
    step();
  endtask

  task automatic test_rfc_vector();
    logic [255:0] k;
    logic [95:0]  n;
    logic [31:0]  w0;
    bit ok;
    int l;
    for (int i = 0; i < 32; i++) k[8 * i +: 8] = i[7:0];
    n = {32'h00000000, 32'h4a000000, 32'h09000000};
    lat = 4;
    do_load(k, n, 32'd1);
    tests_run++; if (bstart[0] !== 1'b1) begin fails++; $display("FAIL rfc_start_latency got %b want 1", bstart[0]); end
    wait_valid(50, ok, l);
    tests_run++; if (!ok) begin fails++; $display("FAIL rfc_timeout got no ks_valid want ks_valid"); end
    tests_run++; if (l != 1) begin fails++; $display("FAIL rfc_valid_latency got %0d want 1", l); end
    w0 = ks_data[0][31:0];
    tests_run++; if (w0 !== 32'he4e7f110) begin fails++; $display("FAIL rfc_w0 got %h want e4e7f110", w0); end
    tests_run++; if (ks_data[0] !== expect_ks(k, n, 32'd1)) begin fails++; $display("FAIL rfc_block got %h want %h", ks_data[0], expect_ks(k, n, 32'd1)); end
    tests_run++; if (ks_counter[0] !== 32'd1) begin fails++; $display("FAIL rfc_counter got %h want 1", ks_counter[0]); end
    test_backpressure(k, n);
  endtask

  task automatic test_backpressure(input logic [255:0] k, input logic [95:0] n);
    bit stable;
    bit ok;
    int l;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (ks_valid[0] !== 1'b1 || ks_data[0] !== expect_ks(k, n, 32'd1) || ks_counter[0] !== 32'd1) stable = 1'b0;
      step();
    end
    tests_run++; if (!stable) begin fails++; $display("FAIL bp_hold_stable got unstable want stable"); end
    consume();
    tests_run++; if (bstart[0] !== 1'b1) begin fails++; $display("FAIL bp_relaunch got %b want 1", bstart[0]); end
    wait_valid(50, ok, l);
    tests_run++; if (!ok || ks_counter[0] !== 32'd2) begin fails++; $display("FAIL bp_next_counter got %h want 2", ks_counter[0]); end
    tests_run++; if (ks_data[0] !== expect_ks(k, n, 32'd2)) begin fails++; $display("FAIL bp_next_block got %h want %h", ks_data[0], expect_ks(k, n, 32'd2)); end
    abandon();
    tests_run++; if (ks_valid[0] !== 1'b0 || cfg_ready[0] !== 1'b1) begin fails++; $display("FAIL bp_stop_hold got valid=%b ready=%b want 0/1", ks_valid[0], cfg_ready[0]); end
  endtask

  task automatic test_random_stream();
    logic [255:0] k;
    logic [95:0]  n;
    logic [31:0]  c0;
    bit ok;
    int l;
    for (int i = 0; i < 8; i++) k[32 * i +: 32] = $urandom;
    for (int i = 0; i < 3; i++) n[32 * i +: 32] = $urandom;
    c0 = $urandom_range(32'hFFFF0000, 0);
    lat = $urandom_range(6, 1);
    do_load(k, n, c0);
    for (int b = 0; b < 8; b++) begin
      wait_valid(60, ok, l);
      tests_run++; if (!ok || ks_counter[0] !== c0 + b) begin fails++; $display("FAIL stream_counter[%0d] got %h want %h", b, ks_counter[0], c0 + b); end
      tests_run++; if (ks_data[0] !== expect_ks(k, n, c0 + b)) begin fails++; $display("FAIL stream_block[%0d] got %h want %h", b, ks_data[0], expect_ks(k, n, c0 + b)); end
      repeat ($urandom_range(3, 0)) step();
      lat = $urandom_range(6, 1);
      consume();
      tests_run++; if (bstart[0] !== 1'b1) begin fails++; $display("FAIL stream_back_to_back[%0d] got %b want 1", b, bstart[0]); end
    end
    abandon();
    tests_run++; if (cfg_ready[0] !== 1'b1) begin fails++; $display("FAIL stream_stop_launch got %b want 1", cfg_ready[0]); end
    tests_run++; if (g_blk[0].overlaps != 0) begin fails++; $display("FAIL single_in_flight got %0d overlaps want 0", g_blk[0].overlaps); end
  endtask

  task automatic test_wrap();
    logic [255:0] k;
    logic [95:0]  n;
    int unsigned s0;
    bit ok;
    bit seen;
    int l;
    for (int i = 0; i < 8; i++) k[32 * i +: 32] = $urandom;
    for (int i = 0; i < 3; i++) n[32 * i +: 32] = $urandom;
    lat = 3;
    do_load(k, n, 32'hFFFFFFFF);
    wait_valid(50, ok, l);
    tests_run++; if (!ok || ks_counter[0] !== 32'hFFFFFFFF || ks_valid[1] !== 1'b1) begin fails++; $display("FAIL wrap_last_block got ctr=%h v1=%b want ffffffff/1", ks_counter[0], ks_valid[1]); end
    tests_run++; if (ks_data[0] !== expect_ks(k, n, 32'hFFFFFFFF)) begin fails++; $display("FAIL wrap_last_data got %h want %h", ks_data[0], expect_ks(k, n, 32'hFFFFFFFF)); end
    consume();
    s0 = g_blk[0].starts;
    tests_run++; if (exhausted[0] !== 1'b1 || cfg_ready[0] !== 1'b1) begin fails++; $display("FAIL wrap0_exhausted got exh=%b rdy=%b want 1/1", exhausted[0], cfg_ready[0]); end
    tests_run++; if (exhausted[1] !== 1'b0) begin fails++; $display("FAIL wrap1_not_exhausted got %b want 0", exhausted[1]); end
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (ks_valid[1]) seen = 1'b1; else step();
    end
    tests_run++; if (!seen || ks_counter[1] !== 32'd0) begin fails++; $display("FAIL wrap1_counter got %h want 0", ks_counter[1]); end
    tests_run++; if (ks_data[1] !== expect_ks(k, n, 32'd0)) begin fails++; $display("FAIL wrap1_data got %h want %h", ks_data[1], expect_ks(k, n, 32'd0)); end
    tests_run++; if (g_blk[0].starts != s0 || ks_valid[0] !== 1'b0) begin fails++; $display("FAIL wrap0_no_more_start got %0d starts want %0d", g_blk[0].starts, s0); end
    abandon();
    do_load(k, n, 32'd5);
    tests_run++; if (exhausted[0] !== 1'b0) begin fails++; $display("FAIL wrap0_exhausted_clear got %b want 0", exhausted[0]); end
    abandon();
    tests_run++; if (cfg_ready[0] !== 1'b1 || cfg_ready[1] !== 1'b1) begin fails++; $display("FAIL wrap_return_idle got %b%b want 11", cfg_ready[0], cfg_ready[1]); end
  endtask

  task automatic test_stop_busy();
    logic [255:0] k;
    logic [95:0]  n;
    int unsigned s0;
    bit any_valid;
    bit ok;
    int l;
    for (int i = 0; i < 8; i++) k[32 * i +: 32] = $urandom;
    for (int i = 0; i < 3; i++) n[32 * i +: 32] = $urandom;
    lat = 8;
    s0 = g_blk[0].starts;
    do_load(k, n, 32'd100);
    step();
    abandon();
    any_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (ks_valid[0]) any_valid = 1'b1;
      step();
    end
    tests_run++; if (any_valid) begin fails++; $display("FAIL stop_busy_valid got 1 want 0"); end
    tests_run++; if (cfg_ready[0] !== 1'b1 || bfin[0] !== 1'b1) begin fails++; $display("FAIL stop_busy_idle got rdy=%b fin=%b want 1/1", cfg_ready[0], bfin[0]); end
    tests_run++; if (g_blk[0].starts != s0 + 1) begin fails++; $display("FAIL stop_busy_starts got %0d want %0d", g_blk[0].starts, s0 + 1); end
    lat = 2;
    do_load(k, n, 32'd200);
    wait_valid(50, ok, l);
    tests_run++; if (!ok || ks_counter[0] !== 32'd200 || ks_data[0] !== expect_ks(k, n, 32'd200)) begin fails++; $display("FAIL stop_relaunch got ctr=%h want c8", ks_counter[0]); end
    abandon();
  endtask

  task automatic test_reset_mid();
    logic [255:0] k;
    logic [95:0]  n;
    bit early;
    bit ok;
    int l;
    int c;
    for (int i = 0; i < 8; i++) k[32 * i +: 32] = $urandom;
    for (int i = 0; i < 3; i++) n[32 * i +: 32] = $urandom;
    lat = 12;
    do_load(k, n, 32'd7);
    repeat (3) step();
    clear_n = 1'b0;
    #1;
    tests_run++; if (ks_valid[0] !== 1'b0 || ks_data[0] !== 512'd0 || ks_counter[0] !== 32'd0 || exhausted[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_outputs got v=%b ctr=%h want 0/0", ks_valid[0], ks_counter[0]); end
    tests_run++; if (cfg_ready[0] !== 1'b1 || bstart[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_idle got rdy=%b start=%b want 1/0", cfg_ready[0], bstart[0]); end
    step();
    clear_n = 1'b1;
    lat = 3;
    do_load(k, n, 32'd9);
    early = 1'b0;
    c = 0;
    while (!bfin[0] && c < 40) begin
      if (bstart[0]) early = 1'b1;
      step();
      c++;
    end
    tests_run++; if (early || c == 0) begin fails++; $display("FAIL rst_mid_wait_finished got early=%b busy_cycles=%0d want 0/>0", early, c); end
    tests_run++; if (bstart[0] !== 1'b1) begin fails++; $display("FAIL rst_mid_start got %b want 1", bstart[0]); end
    wait_valid(50, ok, l);
    tests_run++; if (!ok || ks_counter[0] !== 32'd9 || ks_data[0] !== expect_ks(k, n, 32'd9)) begin fails++; $display("FAIL rst_mid_block got ctr=%h want 9", ks_counter[0]); end
    abandon();
  endtask

  task automatic test_cfg_in_hold();
    logic [255:0] k;
    logic [95:0]  n;
    logic [31:0]  c0;
    bit ok;
    int l;
    for (int i = 0; i < 8; i++) k[32 * i +: 32] = $urandom;
    for (int i = 0; i < 3; i++) n[32 * i +: 32] = $urandom;
    c0 = $urandom_range(32'h7FFFFFFF, 0);
    lat = 2;
    do_load(k, n, c0);
    for (int b = 0; b < 3; b++) begin
      wait_valid(50, ok, l);
      tests_run++; if (!ok || ks_counter[0] !== c0 + b || ks_data[0] !== expect_ks(k, n, c0 + b)) begin fails++; $display("FAIL hold_cfg[%0d] got ctr=%h want %h", b, ks_counter[0], c0 + b); end
      do_load(~k, ~n, 32'h0);
      consume();
    end
    abandon();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rfc_vector();
    test_random_stream();
    test_wrap();
    test_stop_busy();
    test_reset_mid();
    test_cfg_in_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
